// File: rtl/uart_packet_rx.sv
// UART receiver that collects length-prefixed packets (L, then L payload bytes),
// buffers each one whole, and replays it as an AXIS packet with tlast on the final byte.
module uart_packet_rx #(
  parameter int AXIS_TDATA_WIDTH   = 8,
  parameter int MAXIMUM_PACKET_LEN = 16,
  parameter int CLOCK_FREQUENCY    = 20_000_000,
  parameter int BAUD_RATE          = 1_000_000,
  parameter int TIMEOUT_BITS       = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_uart_rx,
  output logic                        o_m_axis_tvalid,
  input  logic                        i_m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] o_m_axis_tdata,
  output logic                        o_m_axis_tlast,
  output logic                        o_m_axis_tkeep,
  output logic                        o_frame_error,
  output logic                        o_len_error,
  output logic                        o_timeout,
  output logic                        o_overrun
);
  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int AW           = $clog2(MAXIMUM_PACKET_LEN);
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

  if (AXIS_TDATA_WIDTH != 8) begin : g_bad_width
    $error("uart_packet_rx: AXIS_TDATA_WIDTH must be 8");
  end
  if (MAXIMUM_PACKET_LEN < 2 || MAXIMUM_PACKET_LEN > 256 ||
      (MAXIMUM_PACKET_LEN & (MAXIMUM_PACKET_LEN - 1)) != 0) begin : g_bad_len
    $error("uart_packet_rx: MAXIMUM_PACKET_LEN must be a power of two in 2..256");
  end
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT * BAUD_RATE != CLOCK_FREQUENCY) begin : g_bad_baud
    $error("uart_packet_rx: CLOCK_FREQUENCY/BAUD_RATE must be an integer >= 4");
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {PK_WAIT_LEN, PK_RECV, PK_EMIT} pk_state_t;

  // ---------------- bit receiver ----------------
  logic [1:0]    r_sync;
  rx_state_t     r_rx_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx_byte;
  logic          r_rx_strobe;
  logic          r_frame_error;
  logic          w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync        <= 2'b11;
      r_rx_state    <= RX_IDLE;
      r_clk_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_rx_byte     <= '0;
      r_rx_strobe   <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_sync        <= {r_sync[0], i_uart_rx};
      r_rx_strobe   <= 1'b0;
      r_frame_error <= 1'b0;
      unique case (r_rx_state)
        RX_IDLE: if (!w_rx) begin
          r_rx_state <= RX_START;
          r_clk_cnt  <= '0;
        end
        // Resample mid start bit so short glitches are rejected as false starts.
        RX_START: if (r_clk_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
          r_clk_cnt  <= '0;
          r_bit_idx  <= '0;
          r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
        end else r_clk_cnt <= r_clk_cnt + 1'b1;
        RX_DATA: if (r_clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          r_clk_cnt <= '0;
          r_shift   <= {w_rx, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
        end else r_clk_cnt <= r_clk_cnt + 1'b1;
        RX_STOP: if (r_clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          r_clk_cnt <= '0;
          if (w_rx) begin
            r_rx_strobe <= 1'b1;
            r_rx_byte   <= r_shift;
            r_rx_state  <= RX_IDLE;
          end else begin
            r_frame_error <= 1'b1;
            r_rx_state    <= RX_BREAK;
          end
        end else r_clk_cnt <= r_clk_cnt + 1'b1;
        RX_BREAK: if (w_rx) r_rx_state <= RX_IDLE;
        default:  r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- packet FSM ----------------
  pk_state_t     r_pk_state;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [TW-1:0] r_idle_cnt;
  logic [7:0]    r_mem [MAXIMUM_PACKET_LEN];
  logic          r_tvalid;
  logic [7:0]    r_tdata;
  logic          r_tlast;
  logic          r_len_error;
  logic          r_timeout;
  logic          r_overrun;
  logic          w_len_ok;
  logic          w_wr;
  logic [AW-1:0] w_rptr_nxt;

  // Full 8-bit compare: a byte like 0x10 must not alias to a small length.
  assign w_len_ok   = (r_rx_byte != 8'd0) && ({1'b0, r_rx_byte} < 9'(MAXIMUM_PACKET_LEN));
  assign w_wr       = (r_pk_state == PK_RECV) && r_rx_strobe;
  assign w_rptr_nxt = r_rptr + 1'b1;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= r_rx_byte;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pk_state  <= PK_WAIT_LEN;
      r_len       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_idle_cnt  <= '0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tlast     <= 1'b0;
      r_len_error <= 1'b0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_len_error <= 1'b0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
      unique case (r_pk_state)
        PK_WAIT_LEN: if (r_rx_strobe) begin
          if (w_len_ok) begin
            r_len      <= r_rx_byte[AW-1:0];
            r_wptr     <= '0;
            r_idle_cnt <= '0;
            r_pk_state <= PK_RECV;
          end else r_len_error <= 1'b1;
        end
        PK_RECV: begin
          if (r_frame_error) r_pk_state <= PK_WAIT_LEN;
          else if (r_rx_strobe) begin
            r_wptr     <= r_wptr + 1'b1;
            r_idle_cnt <= '0;
            if (r_wptr == r_len - 1'b1) begin
              // For L==1 the first byte is still in flight to the buffer.
              r_tdata    <= (r_wptr == '0) ? r_rx_byte : r_mem[0];
              r_tlast    <= (r_len == AW'(1));
              r_tvalid   <= 1'b1;
              r_rptr     <= '0;
              r_pk_state <= PK_EMIT;
            end
          end else if (r_idle_cnt == TW'(TIMEOUT_CLKS - 1)) begin
            r_timeout  <= 1'b1;
            r_pk_state <= PK_WAIT_LEN;
          end else if (r_idle_cnt != '1) r_idle_cnt <= r_idle_cnt + 1'b1;
        end
        PK_EMIT: begin
          if (r_rx_strobe) r_overrun <= 1'b1;
          if (r_tvalid && i_m_axis_tready) begin
            if (r_tlast) begin
              r_tvalid   <= 1'b0;
              r_tlast    <= 1'b0;
              r_pk_state <= PK_WAIT_LEN;
            end else begin
              r_rptr  <= w_rptr_nxt;
              r_tdata <= r_mem[w_rptr_nxt];
              r_tlast <= (w_rptr_nxt == r_len - 1'b1);
            end
          end
        end
        default: r_pk_state <= PK_WAIT_LEN;
      endcase
    end
  end

  assign o_m_axis_tvalid = r_tvalid;
  assign o_m_axis_tdata  = r_tdata;
  assign o_m_axis_tlast  = r_tlast;
  assign o_m_axis_tkeep  = r_tvalid;
  assign o_frame_error   = r_frame_error;
  assign o_len_error     = r_len_error;
  assign o_timeout       = r_timeout;
  assign o_overrun       = r_overrun;
endmodule

// File: tb/tb_uart_packet_rx.sv
// Bench for uart_packet_rx: table of packet frames plus directed stall, timeout,
// glitch, overrun and reset sequences. A single process drives, monitors and scores.
`timescale 1ns/1ps
module tb_uart_packet_rx;
  localparam int CPB = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tready = 1'b1;
  logic       tvalid, tlast, tkeep, fe, le, to, ovr;
  logic [7:0] tdata;

  always #25 clk = ~clk;

  uart_packet_rx dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx),
    .o_m_axis_tvalid(tvalid), .i_m_axis_tready(tready),
    .o_m_axis_tdata(tdata), .o_m_axis_tlast(tlast), .o_m_axis_tkeep(tkeep),
    .o_frame_error(fe), .o_len_error(le), .o_timeout(to), .o_overrun(ovr)
  );

  int tests = 0, fails = 0;
  int cyc = 0, n_fe = 0, n_le = 0, n_to = 0, n_ovr = 0, n_beats = 0;
  logic [7:0] beat_d [256];
  logic       beat_l [256];
  int         beat_c [256];
  int   mode = 0;   // 0: tready high, 1: pattern 1,0,0 repeating, 2: tready low
  int   phase = 0;
  logic prev_v = 0, prev_r = 0, prev_l = 0, prev_rst = 0;
  logic [7:0] prev_d = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mon();
    cyc++;
    if (fe) n_fe++;
    if (le) n_le++;
    if (to) n_to++;
    if (ovr) n_ovr++;
    if (rst_n && prev_rst) begin
      if (prev_v && !prev_r) begin
        check("hold_tvalid", tvalid, 1);
        check("hold_tdata", tdata, prev_d);
        check("hold_tlast", tlast, prev_l);
      end
      if (prev_v && prev_r && prev_l) check("tvalid_drop_after_tlast", tvalid, 0);
    end
    if (rst_n && tvalid && tready && n_beats < 256) begin
      check("tkeep", tkeep, 1);
      beat_d[n_beats] = tdata;
      beat_l[n_beats] = tlast;
      beat_c[n_beats] = cyc;
      n_beats++;
    end
    prev_v = tvalid; prev_r = tready; prev_l = tlast; prev_d = tdata; prev_rst = rst_n;
  endtask

  // Each tick: wait an edge, drive tready for the next edge, then observe.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      case (mode)
        0: tready = 1'b1;
        1: begin tready = (phase == 0); phase = (phase + 1) % 3; end
        default: tready = 1'b0;
      endcase
      mon();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
    rx = stop_ok; tick(CPB);
    if (!stop_ok) begin rx = 1'b1; tick(CPB); end
  endtask

  typedef struct {
    int         n;
    logic [7:0] b [4];
    logic       bad_last;
    int         exp_n;
    logic [7:0] exp_d [3];
    int         exp_le;
    int         exp_fe;
  } vec_t;

  vec_t vt [6];
  int s_b, s_fe, s_le, s_to, s_ovr;

  task automatic snap();
    s_b = n_beats; s_fe = n_fe; s_le = n_le; s_to = n_to; s_ovr = n_ovr;
  endtask

  initial begin
    #(50 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4, '{8'h03, 8'hA5, 8'h5A, 8'hFF}, 1'b0, 3, '{8'hA5, 8'h5A, 8'hFF}, 0, 0};
    vt[1] = '{1, '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 0, '{8'h00, 8'h00, 8'h00}, 1, 0};
    vt[2] = '{1, '{8'h10, 8'h00, 8'h00, 8'h00}, 1'b0, 0, '{8'h00, 8'h00, 8'h00}, 1, 0};
    vt[3] = '{2, '{8'h01, 8'h42, 8'h00, 8'h00}, 1'b0, 1, '{8'h42, 8'h00, 8'h00}, 0, 0};
    vt[4] = '{3, '{8'h02, 8'h11, 8'h22, 8'h00}, 1'b1, 0, '{8'h00, 8'h00, 8'h00}, 0, 1};
    vt[5] = '{3, '{8'h02, 8'hC3, 8'h3C, 8'h00}, 1'b0, 2, '{8'hC3, 8'h3C, 8'h00}, 0, 0};

    // Reset state
    tick(4);
    check("rst_tvalid", tvalid, 0); check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);   check("rst_tkeep", tkeep, 0);
    check("rst_frame_error", fe, 0); check("rst_len_error", le, 0);
    check("rst_timeout", to, 0);    check("rst_overrun", ovr, 0);
    rst_n = 1'b1;
    tick(5);

    // Table-driven frames, tready held high
    for (int v = 0; v < 6; v++) begin
      snap();
      for (int k = 0; k < vt[v].n; k++)
        send_byte(vt[v].b[k], !(vt[v].bad_last && k == vt[v].n - 1));
      tick(30);
      check($sformatf("v%0d_beats", v), n_beats - s_b, vt[v].exp_n);
      if (n_beats - s_b == vt[v].exp_n)
        for (int k = 0; k < vt[v].exp_n; k++) begin
          check($sformatf("v%0d_tdata%0d", v, k), beat_d[s_b + k], vt[v].exp_d[k]);
          check($sformatf("v%0d_tlast%0d", v, k), beat_l[s_b + k], k == vt[v].exp_n - 1);
          if (k > 0) check($sformatf("v%0d_no_bubble%0d", v, k),
                           beat_c[s_b + k], beat_c[s_b + k - 1] + 1);
        end
      check($sformatf("v%0d_len_error", v), n_le - s_le, vt[v].exp_le);
      check($sformatf("v%0d_frame_error", v), n_fe - s_fe, vt[v].exp_fe);
      check($sformatf("v%0d_timeout", v), n_to - s_to, 0);
      check($sformatf("v%0d_overrun", v), n_ovr - s_ovr, 0);
    end

    // Same 3-byte frame under a stalling consumer
    snap(); mode = 1; phase = 0;
    send_byte(8'h03, 1); send_byte(8'hA5, 1); send_byte(8'h5A, 1); send_byte(8'hFF, 1);
    tick(40);
    mode = 0;
    check("stall_beats", n_beats - s_b, 3);
    if (n_beats - s_b == 3) begin
      check("stall_d0", beat_d[s_b], 8'hA5); check("stall_l0", beat_l[s_b], 0);
      check("stall_d1", beat_d[s_b + 1], 8'h5A); check("stall_l1", beat_l[s_b + 1], 0);
      check("stall_d2", beat_d[s_b + 2], 8'hFF); check("stall_l2", beat_l[s_b + 2], 1);
    end
    check("stall_tvalid_end", tvalid, 0);

    // Idle timeout drops a partial packet
    snap();
    send_byte(8'h02, 1); send_byte(8'h11, 1);
    tick(600);
    check("timeout_not_early", n_to - s_to, 0);
    tick(100);
    check("timeout_pulse", n_to - s_to, 1);
    check("timeout_no_beats", n_beats - s_b, 0);
    snap();
    send_byte(8'h01, 1); send_byte(8'h77, 1);
    tick(30);
    check("after_timeout_beats", n_beats - s_b, 1);
    check("after_timeout_d", beat_d[s_b], 8'h77);
    check("after_timeout_l", beat_l[s_b], 1);

    // Half-bit glitch is a false start
    snap();
    rx = 1'b0; tick(CPB / 2); rx = 1'b1; tick(250);
    check("glitch_frame_error", n_fe - s_fe, 0);
    check("glitch_len_error", n_le - s_le, 0);
    check("glitch_beats", n_beats - s_b, 0);

    // Byte arriving during a stalled EMIT is an overrun
    snap(); mode = 2;
    send_byte(8'h01, 1); send_byte(8'h33, 1);
    tick(5);
    check("ovr_tvalid", tvalid, 1); check("ovr_tdata", tdata, 8'h33); check("ovr_tlast", tlast, 1);
    send_byte(8'h99, 1);
    tick(5);
    check("ovr_pulse", n_ovr - s_ovr, 1);
    check("ovr_tdata_kept", tdata, 8'h33);
    mode = 0;
    tick(5);
    check("ovr_beats", n_beats - s_b, 1);
    check("ovr_beat_d", beat_d[s_b], 8'h33);
    check("ovr_beat_l", beat_l[s_b], 1);

    // Reset mid-byte while a beat is stalled
    mode = 2;
    send_byte(8'h01, 1); send_byte(8'h55, 1);
    tick(5);
    check("pre_rst_tvalid", tvalid, 1);
    rx = 1'b0; tick(50);
    rst_n = 1'b0; rx = 1'b1;
    tick(1);
    check("mid_rst_tvalid", tvalid, 0); check("mid_rst_tdata", tdata, 0);
    check("mid_rst_tlast", tlast, 0);   check("mid_rst_tkeep", tkeep, 0);
    check("mid_rst_pulses", {fe, le, to, ovr}, 4'b0000);
    tick(3);
    rst_n = 1'b1; mode = 0;
    tick(5);
    snap();
    send_byte(8'h02, 1); send_byte(8'hDE, 1); send_byte(8'hAD, 1);
    tick(30);
    check("post_rst_beats", n_beats - s_b, 2);
    if (n_beats - s_b == 2) begin
      check("post_rst_d0", beat_d[s_b], 8'hDE);     check("post_rst_l0", beat_l[s_b], 0);
      check("post_rst_d1", beat_d[s_b + 1], 8'hAD); check("post_rst_l1", beat_l[s_b + 1], 1);
    end
    check("post_rst_errors", (n_fe - s_fe) + (n_le - s_le) + (n_to - s_to) + (n_ovr - s_ovr), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
